pattern_gen_multi: RTL and testbench

//  Parametrised VGA test-pattern generator. It is the successor to the fixed-gradient image

---
 rtl/pattern_gen_multi.sv | 142 ++++++++++++++
 tb/tb_pattern_gen_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_multi.sv
// VGA test-pattern generator: gradient / colour bars / checker / solid, switched at frame start.
// Latency: 1 cycle from pix_x/pix_y to every registered output.
// Backpressure: none; the pixel stream advances every cycle and cannot be stalled.
module pattern_gen_multi #(
    parameter int COLOR_W     = 3,
    parameter int COORD_W     = 11,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int BAR_W       = 100,
    parameter int CHECK_SHIFT = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [1:0]         mode_in,
    input  logic               enable_in,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out,
    output logic               active_out,
    output logic               frame_start_out,
    output logic [7:0]         frame_cnt_out
);

    localparam int N     = 2 ** COLOR_W;
    localparam int SEG_I = H_ACTIVE / N;

    localparam logic [COORD_W:0]   H_ACT = H_ACTIVE[COORD_W:0];
    localparam logic [COORD_W-1:0] V_ACT = V_ACTIVE[COORD_W-1:0];
    localparam logic [COORD_W:0]   SEG   = SEG_I[COORD_W:0];
    localparam logic [COORD_W:0]   STEP  = SCROLL_STEP[COORD_W:0];
    localparam logic [COORD_W-1:0] BAR   = BAR_W[COORD_W-1:0];
    localparam logic [COLOR_W-1:0] ONES  = '1;

    logic [1:0]         mode_q;
    logic [COORD_W-1:0] scroll_q;
    logic [7:0]         cnt_q;
    logic               org_d;

    logic               org;
    logic               fs;
    logic               active;
    logic [COORD_W:0]   scroll_sum;
    logic [COORD_W:0]   scroll_nx;
    logic [COORD_W:0]   scroll_e;
    logic [7:0]         cnt_e;
    logic [1:0]         mode_e;
    logic [COORD_W:0]   xs_sum;
    logic [COORD_W:0]   xs;
    logic [COORD_W:0]   g;
    logic [COORD_W-1:0] bar_idx;
    logic [2:0]         bar_rgb;
    logic               chk;
    logic [COLOR_W-1:0] r_nx;
    logic [COLOR_W-1:0] g_nx;
    logic [COLOR_W-1:0] b_nx;
    logic               unused_bits;

    always_comb begin
        org        = (pix_x == '0) && (pix_y == '0);
        fs         = org && !org_d;
        active     = ({1'b0, pix_x} < H_ACT) && (pix_y < V_ACT);

        // Scroll wraps by subtraction so it never leaves 0..H_ACTIVE-1.
        scroll_sum = {1'b0, scroll_q} + STEP;
        scroll_nx  = (scroll_sum >= H_ACT) ? scroll_sum - H_ACT : scroll_sum;

        // The frame-start pixel already uses the freshly updated state.
        scroll_e   = fs ? scroll_nx : {1'b0, scroll_q};
        cnt_e      = fs ? cnt_q + 8'd1 : cnt_q;
        mode_e     = fs ? mode_in : mode_q;

        xs_sum     = {1'b0, pix_x} + scroll_e;
        xs         = (xs_sum >= H_ACT) ? xs_sum - H_ACT : xs_sum;
        g          = xs / SEG;

        bar_idx    = pix_x / BAR;
        bar_rgb    = ~bar_idx[2:0];
        chk        = pix_x[CHECK_SHIFT] ^ pix_y[CHECK_SHIFT] ^ cnt_e[6];

        r_nx = '0;
        g_nx = '0;
        b_nx = '0;
        if (active && enable_in) begin
            unique case (mode_e)
                2'd0: begin
                    r_nx = g[COLOR_W-1:0];
                    g_nx = g[COLOR_W-1:0] >> 1;
                    b_nx = g[COLOR_W-1:0] >> 2;
                end
                2'd1: begin
                    r_nx = bar_rgb[2] ? ONES : '0;
                    g_nx = bar_rgb[1] ? ONES : '0;
                    b_nx = bar_rgb[0] ? ONES : '0;
                end
                2'd2: begin
                    r_nx = chk ? ONES : '0;
                    g_nx = chk ? ONES : '0;
                    b_nx = chk ? ONES : '0;
                end
                default: begin
                    r_nx = cnt_e[COLOR_W-1:0];
                    g_nx = ~cnt_e[COLOR_W-1:0];
                    b_nx = cnt_e[7 -: COLOR_W];
                end
            endcase
        end
    end

    assign unused_bits = ^{g[COORD_W:COLOR_W], bar_idx[COORD_W-1:3], cnt_e};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q          <= '0;
            scroll_q        <= '0;
            cnt_q           <= '0;
            org_d           <= 1'b0;
            red_out         <= '0;
            green_out       <= '0;
            blue_out        <= '0;
            active_out      <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            org_d           <= org;
            if (fs) begin
                mode_q   <= mode_in;
                scroll_q <= scroll_nx[COORD_W-1:0];
                cnt_q    <= cnt_q + 8'd1;
            end
            red_out         <= r_nx;
            green_out       <= g_nx;
            blue_out        <= b_nx;
            active_out      <= active;
            frame_start_out <= fs;
        end
    end

    assign frame_cnt_out = cnt_q;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Bench for pattern_gen_multi: directed spec scenarios plus randomized frames against a reference model.
module tb_pattern_gen_multi;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [1:0]  mode_in;
    logic        enable_in;
    logic [2:0]  red_out, green_out, blue_out;
    logic        active_out, frame_start_out;
    logic [7:0]  frame_cnt_out;

    int total = 0;
    int bad   = 0;

    // Reference model state (spec-level integers)
    int m_mode, m_scroll, m_cnt;
    bit m_org_prev;
    logic [2:0] e_r, e_g, e_b;
    logic       e_act, e_fs;
    logic [7:0] e_cnt;

    pattern_gen_multi dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .pix_x(pix_x), .pix_y(pix_y),
        .mode_in(mode_in), .enable_in(enable_in), .red_out(red_out),
        .green_out(green_out), .blue_out(blue_out), .active_out(active_out),
        .frame_start_out(frame_start_out), .frame_cnt_out(frame_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_mode = 0; m_scroll = 0; m_cnt = 0; m_org_prev = 0;
    endtask

    // Apply one pixel, advance the model, and return just after the capturing edge.
    task automatic drive(input int x, input int y, input int mode, input bit en);
        bit org, fs, act;
        int r, g, b, gg, bi, c;
        pix_x = 11'(x); pix_y = 11'(y); mode_in = 2'(mode); enable_in = en;
        org = (x == 0) && (y == 0);
        fs  = org && !m_org_prev;
        m_org_prev = org;
        if (fs) begin
            m_mode   = mode;
            m_cnt    = (m_cnt + 1) % 256;
            m_scroll = (m_scroll + 4) % 800;
        end
        act = (x < 800) && (y < 600);
        r = 0; g = 0; b = 0;
        if (act && en) begin
            case (m_mode)
                0: begin gg = ((x + m_scroll) % 800) / 100; r = gg; g = gg / 2; b = gg / 4; end
                1: begin
                    bi = 7 - ((x / 100) % 8);
                    r = ((bi / 4) % 2) ? 7 : 0;
                    g = ((bi / 2) % 2) ? 7 : 0;
                    b = (bi % 2) ? 7 : 0;
                end
                2: begin
                    c = ((x / 32) % 2) ^ ((y / 32) % 2) ^ ((m_cnt / 64) % 2);
                    r = c ? 7 : 0; g = r; b = r;
                end
                default: begin r = m_cnt % 8; g = 7 - r; b = m_cnt / 32; end
            endcase
        end
        e_r = 3'(r); e_g = 3'(g); e_b = 3'(b);
        e_act = act; e_fs = fs; e_cnt = 8'(m_cnt);
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b1; pix_x = 11'd5; pix_y = 11'd5; mode_in = 2'd2; enable_in = 1'b1;
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        #2;
        model_reset();
        total++;
        if ({red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got r%0d g%0d b%0d act%0b fs%0b cnt%0d want all 0",
                     red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out);
        end
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_n_in = 1'b1;
    endtask

    task automatic test_gradient();
        int xs[4] = '{0, 99, 100, 799};
        int want_r[4] = '{0, 0, 1, 7};
        for (int i = 0; i < 4; i++) begin
            drive(xs[i], 5, 0, 1'b1);
            total++;
            if (red_out !== 3'(want_r[i]) || {red_out, green_out, blue_out} !== {e_r, e_g, e_b}) begin
                bad++;
                $display("FAIL gradient x=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         xs[i], red_out, green_out, blue_out, e_r, e_g, e_b);
            end
        end
        total++;
        if (green_out !== 3'd3 || blue_out !== 3'd1) begin
            bad++;
            $display("FAIL gradient_799_gb got g%0d b%0d want g3 b1", green_out, blue_out);
        end
    endtask

    task automatic test_first_frame();
        drive(0, 0, 0, 1'b1);
        total++;
        if (frame_start_out !== 1'b1 || frame_cnt_out !== 8'd1 || red_out !== e_r) begin
            bad++;
            $display("FAIL first_frame got fs%0b cnt%0d r%0d want fs1 cnt1 r%0d",
                     frame_start_out, frame_cnt_out, red_out, e_r);
        end
        drive(1, 0, 0, 1'b1);
        total++;
        if (frame_start_out !== 1'b0) begin
            bad++;
            $display("FAIL first_frame_pulse_len got fs%0b want 0", frame_start_out);
        end
    endtask

    task automatic test_blank();
        drive(800, 10, 0, 1'b1);
        total++;
        if ({red_out, green_out, blue_out, active_out} !== 10'd0) begin
            bad++;
            $display("FAIL blank_x800 got rgb %0d/%0d/%0d act%0b want 0/0/0 act0",
                     red_out, green_out, blue_out, active_out);
        end
        drive(5, 600, 0, 1'b1);
        total++;
        if ({red_out, green_out, blue_out, active_out} !== 10'd0) begin
            bad++;
            $display("FAIL blank_y600 got rgb %0d/%0d/%0d act%0b want 0/0/0 act0",
                     red_out, green_out, blue_out, active_out);
        end
        drive(799, 599, 0, 1'b1);
        total++;
        if (active_out !== 1'b1 || red_out !== e_r) begin
            bad++;
            $display("FAIL blank_corner got act%0b r%0d want act1 r%0d", active_out, red_out, e_r);
        end
        drive(5, 5, 3, 1'b0);
        total++;
        if ({red_out, green_out, blue_out, active_out} !== 10'd1) begin
            bad++;
            $display("FAIL enable_off got rgb %0d/%0d/%0d act%0b want 0/0/0 act1",
                     red_out, green_out, blue_out, active_out);
        end
    endtask

    task automatic test_mode_switch();
        drive(100, 5, 1, 1'b1);
        total++;
        if ({red_out, green_out, blue_out} !== {e_r, e_g, e_b}) begin
            bad++;
            $display("FAIL mode_midframe got %0d/%0d/%0d want %0d/%0d/%0d",
                     red_out, green_out, blue_out, e_r, e_g, e_b);
        end
        drive(0, 0, 1, 1'b1);
        total++;
        if ({red_out, green_out, blue_out} !== 9'o777) begin
            bad++;
            $display("FAIL mode_at_fs got %0d/%0d/%0d want 7/7/7", red_out, green_out, blue_out);
        end
        drive(150, 5, 2, 1'b1);
        total++;
        if ({red_out, green_out, blue_out} !== {e_r, e_g, e_b}) begin
            bad++;
            $display("FAIL mode_held got %0d/%0d/%0d want %0d/%0d/%0d",
                     red_out, green_out, blue_out, e_r, e_g, e_b);
        end
    endtask

    task automatic test_hold_origin();
        int pulses = 0;
        int cnt0;
        drive(5, 5, 0, 1'b1);
        cnt0 = int'(frame_cnt_out);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1'b1);
            if (frame_start_out === 1'b1) pulses++;
        end
        total++;
        if (pulses != 1 || frame_cnt_out !== 8'((cnt0 + 1) % 256)) begin
            bad++;
            $display("FAIL hold_origin got pulses=%0d cnt=%0d want pulses=1 cnt=%0d",
                     pulses, frame_cnt_out, (cnt0 + 1) % 256);
        end
    endtask

    task automatic test_random();
        int x, y, n;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 2);
            for (int h = 0; h < n; h++) begin
                drive(0, 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
                total++;
                if ({red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out} !==
                    {e_r, e_g, e_b, e_act, e_fs, e_cnt}) begin
                    bad++;
                    $display("FAIL random_origin f=%0d got %0d/%0d/%0d a%0b fs%0b c%0d want %0d/%0d/%0d a%0b fs%0b c%0d",
                             f, red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out,
                             e_r, e_g, e_b, e_act, e_fs, e_cnt);
                end
            end
            for (int p = 0; p < 25; p++) begin
                x = $urandom_range(0, 900);
                y = $urandom_range(0, 700);
                if (x == 0 && y == 0) x = 1;
                drive(x, y, $urandom_range(0, 3), $urandom_range(0, 3) != 0);
                total++;
                if ({red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out} !==
                    {e_r, e_g, e_b, e_act, e_fs, e_cnt}) begin
                    bad++;
                    $display("FAIL random_pix (%0d,%0d) got %0d/%0d/%0d a%0b fs%0b c%0d want %0d/%0d/%0d a%0b fs%0b c%0d",
                             x, y, red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out,
                             e_r, e_g, e_b, e_act, e_fs, e_cnt);
                end
            end
        end
    endtask

    task automatic test_scroll_wrap();
        bit saw_top = 0;
        bit wrapped = 0;
        for (int f = 0; f < 300 && !wrapped; f++) begin
            drive(0, 0, 0, 1'b1);
            total++;
            if ({red_out, green_out, blue_out, frame_cnt_out} !== {e_r, e_g, e_b, e_cnt}) begin
                bad++;
                $display("FAIL scroll_frame f=%0d got %0d/%0d/%0d c%0d want %0d/%0d/%0d c%0d",
                         f, red_out, green_out, blue_out, frame_cnt_out, e_r, e_g, e_b, e_cnt);
            end
            if (m_scroll == 796) saw_top = 1;
            if (saw_top && m_scroll == 0) begin
                wrapped = 1;
                total++;
                if (red_out !== 3'd0) begin
                    bad++;
                    $display("FAIL scroll_wrap_red got %0d want 0", red_out);
                end
            end
            drive(799, 5, 0, 1'b1);
            total++;
            if (red_out !== e_r) begin
                bad++;
                $display("FAIL scroll_x799 f=%0d got %0d want %0d", f, red_out, e_r);
            end
        end
        if (!wrapped) begin
            total++;
            bad++;
            $display("FAIL scroll_wrap_timeout got no wrap want wrap within 300 frames");
        end
    endtask

    task automatic test_reset_midframe();
        drive(0, 0, 3, 1'b1);
        drive(300, 200, 3, 1'b1);
        rst_n_in = 1'b0;
        #2;
        model_reset();
        total++;
        if ({red_out, green_out, blue_out, active_out, frame_start_out, frame_cnt_out} !== 17'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs got nonzero cnt%0d act%0b", frame_cnt_out, active_out);
        end
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        drive(400, 200, 3, 1'b1);
        total++;
        if (frame_start_out !== 1'b0 || frame_cnt_out !== 8'd0 || red_out !== e_r) begin
            bad++;
            $display("FAIL reset_mid_nopulse got fs%0b cnt%0d r%0d want fs0 cnt0 r%0d",
                     frame_start_out, frame_cnt_out, red_out, e_r);
        end
        drive(0, 0, 3, 1'b1);
        total++;
        if (frame_start_out !== 1'b1 || frame_cnt_out !== 8'd1 ||
            {red_out, green_out, blue_out} !== {e_r, e_g, e_b}) begin
            bad++;
            $display("FAIL reset_mid_fs got fs%0b cnt%0d rgb %0d/%0d/%0d want fs1 cnt1 %0d/%0d/%0d",
                     frame_start_out, frame_cnt_out, red_out, green_out, blue_out, e_r, e_g, e_b);
        end
    endtask

    initial begin
        test_reset();
        test_gradient();
        test_first_frame();
        test_blank();
        test_mode_switch();
        test_hold_origin();
        test_random();
        test_scroll_wrap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
